// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared encodings and default widths for the FP issue queue
// Purpose: op_sel encoding and default operand/op-code widths shared by the
// issue queue, its FIFO helper and anything that talks to them.
package fp_pkg;

    localparam int FP_DATA_W = 32;
    localparam int FP_OP_W   = 3;

    typedef enum logic [FP_OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_CMP = 3'd4
    } fp_op_e;

endpackage

// File: rtl/fp_sync_fifo.sv
// rtl/fp_sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: power-of-two deep FIFO used for both the command and result queues.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (honoured when not full, or when
//                   a pop happens on the same edge)
//   pop, rdata      read request and head entry (pop ignored when empty)
//   full, empty     occupancy flags
//   count           number of stored entries, $clog2(DEPTH)+1 bits
module fp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_issue_queue.sv
// rtl/fp_issue_queue.sv - credit-gated command/result queue in front of an FP unit
// Purpose: buffers CPU commands, issues them to an execution unit only when the
// result queue is guaranteed room, and buffers in-order results for the CPU.
// Ports:
//   clk, n_rst                   clock, asynchronous reset (active HIGH)
//   op1, op2, op_sel, op_strobe  CPU command; cpu_hold = command queue full
//   result, result_valid, cpu_pop  result queue head and consume strobe
//   exu_valid/op1/op2/sel, exu_ready  issue handshake to the execution unit
//   exu_done, exu_result         in-order completion from the execution unit
//   err_drop, err_under, err_spur, err_clr  sticky error flags and their clear
module fp_issue_queue
    import fp_pkg::*;
#(
    parameter int DATA_W    = FP_DATA_W,
    parameter int OP_W      = FP_OP_W,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [OP_W-1:0]   op_sel,
    input  logic              op_strobe,
    output logic              cpu_hold,
    input  logic              cpu_pop,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              exu_valid,
    output logic [DATA_W-1:0] exu_op1,
    output logic [DATA_W-1:0] exu_op2,
    output logic [OP_W-1:0]   exu_sel,
    input  logic              exu_ready,
    input  logic              exu_done,
    input  logic [DATA_W-1:0] exu_result,
    output logic              err_drop,
    output logic              err_under,
    output logic              err_spur,
    input  logic              err_clr
);

    localparam int CMD_W = 2 * DATA_W + OP_W;
    localparam int CCW   = $clog2(CMD_DEPTH) + 1;
    localparam int RCW   = $clog2(RES_DEPTH) + 1;
    localparam logic [RCW:0] RES_LIM = (RCW + 1)'(RES_DEPTH);

    logic [CMD_W-1:0]  cmd_head;
    logic              cmd_full;
    logic              cmd_empty;
    logic [CCW-1:0]    cmd_count;
    logic              cmd_push;

    logic [DATA_W-1:0] res_head;
    logic              res_full;
    logic              res_empty;
    logic [RCW-1:0]    res_count;
    logic              res_push;
    logic              res_pop;

    logic [RCW-1:0]    inflight;
    logic              credit;
    logic              issue;
    logic              done_ok;

    // Hold comes purely from registered occupancy: an issue on this edge does
    // not open a slot for a strobe on the same edge.
    assign cpu_hold = cmd_full;
    assign cmd_push = op_strobe && !cpu_hold;

    // Credit reserves a result slot for every issued operation, so a legal
    // exu_done can never find the result queue without room.
    assign credit    = ({1'b0, res_count} + {1'b0, inflight}) < RES_LIM;
    assign exu_valid = (cmd_count != '0) && credit;
    assign issue     = exu_valid && exu_ready;

    // Head fields are forced to zero when empty so no stale storage leaks out.
    assign exu_op1 = cmd_empty ? '0 : cmd_head[CMD_W-1 -: DATA_W];
    assign exu_op2 = cmd_empty ? '0 : cmd_head[OP_W +: DATA_W];
    assign exu_sel = cmd_empty ? '0 : cmd_head[OP_W-1:0];

    assign done_ok      = exu_done && (inflight != '0);
    assign res_pop      = cpu_pop && !res_empty;
    assign res_push     = done_ok && (!res_full || res_pop);
    assign result_valid = !res_empty;
    assign result       = res_empty ? '0 : res_head;

    fp_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (n_rst),
        .push  (cmd_push),
        .wdata ({op1, op2, op_sel}),
        .pop   (issue),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    fp_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (n_rst),
        .push  (res_push),
        .wdata (exu_result),
        .pop   (res_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            inflight <= '0;
        end else begin
            case ({issue, done_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Set events win over err_clr on the same edge.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            err_drop  <= 1'b0;
            err_under <= 1'b0;
            err_spur  <= 1'b0;
        end else begin
            if (op_strobe && cpu_hold)        err_drop <= 1'b1;
            else if (err_clr)                 err_drop <= 1'b0;
            if (cpu_pop && res_empty)         err_under <= 1'b1;
            else if (err_clr)                 err_under <= 1'b0;
            if (exu_done && inflight == '0)   err_spur <= 1'b1;
            else if (err_clr)                 err_spur <= 1'b0;
        end
    end

endmodule
